// File: rtl/alu_pkg.sv
// Shared types for the RV32I ID/EX issue stage: ALU opcodes, base opcodes and the
// registered slot presented to the combinational ALU in EX.
package alu_pkg;

    localparam int ALU_XLEN       = 32;
    localparam int ALU_REG_ADDR_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_SLT   = 4'b0010,
        ALU_SLTU  = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_OR    = 4'b0101,
        ALU_AND   = 4'b0110,
        ALU_SLL   = 4'b0111,
        ALU_SRL   = 4'b1000,
        ALU_SRA   = 4'b1001,
        ALU_AUIPC = 4'b1110,
        ALU_LUI   = 4'b1111
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic                      valid;
        alu_op_e                   op;
        logic [ALU_XLEN-1:0]       a;
        logic [ALU_XLEN-1:0]       b;
        logic [ALU_REG_ADDR_W-1:0] rd;
        logic                      rd_wen;
        logic                      is_load;
    } slot_t;

    // ADDI has no subtract form, so funct7[5] only selects SUB for register-register ops.
    function automatic alu_op_e decode_alu_op(input logic [2:0] f3, input logic f7b5,
                                              input logic is_imm);
        case (f3)
            3'b000:  return (f7b5 && !is_imm) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Resolves one source operand: x0, then EX/MEM, then MEM/WB, then register file data.
module operand_fwd_mux
    import alu_pkg::*;
#(
    parameter int XLEN       = ALU_XLEN,
    parameter int REG_ADDR_W = ALU_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] i_rs_addr,
    input  logic [XLEN-1:0]       i_rf_data,
    input  logic                  i_exm_wen,
    input  logic [REG_ADDR_W-1:0] i_exm_rd,
    input  logic [XLEN-1:0]       i_exm_data,
    input  logic                  i_mwb_wen,
    input  logic [REG_ADDR_W-1:0] i_mwb_rd,
    input  logic [XLEN-1:0]       i_mwb_data,
    output logic [XLEN-1:0]       o_data
);

    // The younger EX/MEM result must shadow the older MEM/WB one for the same register.
    always_comb begin
        o_data = i_rf_data;
        if (i_rs_addr == '0) begin
            o_data = '0;
        end else if (i_exm_wen && (i_exm_rd == i_rs_addr)) begin
            o_data = i_exm_data;
        end else if (i_mwb_wen && (i_mwb_rd == i_rs_addr)) begin
            o_data = i_mwb_data;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes OP/OP-IMM/LOAD/LUI/AUIPC, forwards operands and
// registers the slot for the EX ALU, stalling on a load-use hazard.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN       = ALU_XLEN,
    parameter int REG_ADDR_W = ALU_REG_ADDR_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_id_valid,
    output logic                  o_id_ready,
    input  logic [31:0]           i_id_instr,
    input  logic [31:0]           i_id_pc,
    output logic [REG_ADDR_W-1:0] o_rs1_addr,
    output logic [REG_ADDR_W-1:0] o_rs2_addr,
    input  logic [XLEN-1:0]       i_rs1_data,
    input  logic [XLEN-1:0]       i_rs2_data,
    input  logic                  i_exm_wen,
    input  logic [REG_ADDR_W-1:0] i_exm_rd,
    input  logic [XLEN-1:0]       i_exm_data,
    input  logic                  i_mwb_wen,
    input  logic [REG_ADDR_W-1:0] i_mwb_rd,
    input  logic [XLEN-1:0]       i_mwb_data,
    input  logic                  i_flush,
    input  logic                  i_ex_ready,
    output logic                  o_ex_valid,
    output logic [XLEN-1:0]       o_operand_a,
    output logic [XLEN-1:0]       o_operand_b,
    output logic [3:0]            o_alu_op,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic                  o_rd_wen,
    output logic                  o_is_load,
    output logic                  o_illegal
);

    logic [6:0]            w_opcode;
    logic [2:0]            w_f3;
    logic                  w_f7b5;
    logic [REG_ADDR_W-1:0] w_rs1;
    logic [REG_ADDR_W-1:0] w_rs2;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [XLEN-1:0]       w_imm_i;
    logic [XLEN-1:0]       w_imm_u;
    logic [XLEN-1:0]       w_rs1_val;
    logic [XLEN-1:0]       w_rs2_val;
    logic                  w_is_shift;

    assign w_opcode   = i_id_instr[6:0];
    assign w_rd       = i_id_instr[11:7];
    assign w_f3       = i_id_instr[14:12];
    assign w_rs1      = i_id_instr[19:15];
    assign w_rs2      = i_id_instr[24:20];
    assign w_f7b5     = i_id_instr[30];
    assign w_imm_i    = {{(XLEN-12){i_id_instr[31]}}, i_id_instr[31:20]};
    assign w_imm_u    = {i_id_instr[31:12], 12'b0};
    assign w_is_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

    assign o_rs1_addr = i_rst_n ? w_rs1 : '0;
    assign o_rs2_addr = i_rst_n ? w_rs2 : '0;

    operand_fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
        .i_rs_addr (w_rs1),
        .i_rf_data (i_rs1_data),
        .i_exm_wen (i_exm_wen),
        .i_exm_rd  (i_exm_rd),
        .i_exm_data(i_exm_data),
        .i_mwb_wen (i_mwb_wen),
        .i_mwb_rd  (i_mwb_rd),
        .i_mwb_data(i_mwb_data),
        .o_data    (w_rs1_val)
    );

    operand_fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
        .i_rs_addr (w_rs2),
        .i_rf_data (i_rs2_data),
        .i_exm_wen (i_exm_wen),
        .i_exm_rd  (i_exm_rd),
        .i_exm_data(i_exm_data),
        .i_mwb_wen (i_mwb_wen),
        .i_mwb_rd  (i_mwb_rd),
        .i_mwb_data(i_mwb_data),
        .o_data    (w_rs2_val)
    );

    slot_t w_dec;
    logic  w_legal;
    logic  w_rs1_used;
    logic  w_rs2_used;

    // Shift amounts are zero-extended because the ALU compares the whole operand_b.
    always_comb begin
        w_dec      = '0;
        w_legal    = 1'b0;
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_legal    = 1'b1;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
                w_dec.op   = decode_alu_op(w_f3, w_f7b5, 1'b0);
                w_dec.a    = w_rs1_val;
                w_dec.b    = w_is_shift ? {{(XLEN-5){1'b0}}, w_rs2_val[4:0]} : w_rs2_val;
            end
            OPC_OP_IMM: begin
                w_legal    = 1'b1;
                w_rs1_used = 1'b1;
                w_dec.op   = decode_alu_op(w_f3, w_f7b5, 1'b1);
                w_dec.a    = w_rs1_val;
                w_dec.b    = w_is_shift ? {{(XLEN-5){1'b0}}, w_rs2} : w_imm_i;
            end
            OPC_LOAD: begin
                w_legal       = 1'b1;
                w_rs1_used    = 1'b1;
                w_dec.op      = ALU_ADD;
                w_dec.a       = w_rs1_val;
                w_dec.b       = w_imm_i;
                w_dec.is_load = 1'b1;
            end
            OPC_LUI: begin
                w_legal  = 1'b1;
                w_dec.op = ALU_LUI;
                w_dec.b  = w_imm_u;
            end
            OPC_AUIPC: begin
                w_legal  = 1'b1;
                w_dec.op = ALU_AUIPC;
                w_dec.a  = i_id_pc;
                w_dec.b  = w_imm_u;
            end
            default: ;
        endcase
        w_dec.valid  = w_legal;
        w_dec.rd     = w_rd;
        w_dec.rd_wen = w_legal && (w_rd != '0);
    end

    slot_t r_slot;
    logic  r_illegal;
    logic  w_cap;
    logic  w_hz;
    logic  w_xfer;

    // Handshake: the ID instruction moves when i_id_valid && o_id_ready on a clock edge;
    // the EX slot is consumed when o_ex_valid && i_ex_ready, and held unchanged otherwise.
    assign w_cap  = !r_slot.valid || i_ex_ready;
    assign w_hz   = r_slot.valid && r_slot.is_load && (r_slot.rd != '0) &&
                    ((w_rs1_used && (r_slot.rd == w_rs1)) ||
                     (w_rs2_used && (r_slot.rd == w_rs2)));
    assign o_id_ready = i_rst_n && w_cap && !w_hz && !i_flush;
    assign w_xfer     = i_id_valid && o_id_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_slot    <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_xfer && !w_legal;
            if (i_flush) begin
                r_slot.valid <= 1'b0;
            end else if (w_xfer && w_legal) begin
                r_slot <= w_dec;
            end else if (w_cap) begin
                r_slot.valid <= 1'b0;
            end
        end
    end

    assign o_ex_valid  = r_slot.valid;
    assign o_operand_a = r_slot.a;
    assign o_operand_b = r_slot.b;
    assign o_alu_op    = r_slot.op;
    assign o_rd        = r_slot.rd;
    assign o_rd_wen    = r_slot.rd_wen;
    assign o_is_load   = r_slot.is_load;
    assign o_illegal   = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: the driver queues hand-computed slots, a negedge
// monitor pops them whenever EX consumes a slot or an illegal pulse appears.
module tb_alu_issue_stage;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_id_valid;
    logic        o_id_ready;
    logic [31:0] i_id_instr;
    logic [31:0] i_id_pc;
    logic [4:0]  o_rs1_addr, o_rs2_addr;
    logic [31:0] i_rs1_data, i_rs2_data;
    logic        i_exm_wen, i_mwb_wen;
    logic [4:0]  i_exm_rd, i_mwb_rd;
    logic [31:0] i_exm_data, i_mwb_data;
    logic        i_flush, i_ex_ready;
    logic        o_ex_valid;
    logic [31:0] o_operand_a, o_operand_b;
    logic [3:0]  o_alu_op;
    logic [4:0]  o_rd;
    logic        o_rd_wen, o_is_load, o_illegal;

    logic [31:0] rf [32];
    logic [75:0] exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    alu_issue_stage dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_id_valid(i_id_valid), .o_id_ready(o_id_ready),
        .i_id_instr(i_id_instr), .i_id_pc(i_id_pc),
        .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .i_exm_wen(i_exm_wen), .i_exm_rd(i_exm_rd), .i_exm_data(i_exm_data),
        .i_mwb_wen(i_mwb_wen), .i_mwb_rd(i_mwb_rd), .i_mwb_data(i_mwb_data),
        .i_flush(i_flush), .i_ex_ready(i_ex_ready),
        .o_ex_valid(o_ex_valid), .o_operand_a(o_operand_a), .o_operand_b(o_operand_b),
        .o_alu_op(o_alu_op), .o_rd(o_rd), .o_rd_wen(o_rd_wen),
        .o_is_load(o_is_load), .o_illegal(o_illegal)
    );

    // Clock and register-file model (read data follows the requested address).
    always #5 i_clk = ~i_clk;
    assign i_rs1_data = rf[o_rs1_addr];
    assign i_rs2_data = rf[o_rs2_addr];

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [75:0] pk(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [4:0] rd,
                                       input logic wen, input logic ld);
        return {1'b0, op, a, b, rd, wen, ld};
    endfunction

    localparam logic [75:0] ILLEGAL_ENTRY = {1'b1, 75'b0};

    task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    int n_slots = 0;
    always @(negedge i_clk) begin
        logic [75:0] e;
        if (i_rst_n === 1'b1 && (o_illegal || (o_ex_valid && i_ex_ready))) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {74'b0, o_illegal, o_ex_valid}, 76'd0);
            end else begin
                e = exp_q.pop_front();
                n_slots++;
                if (e[75])
                    check($sformatf("illegal_%0d", n_slots), {74'b0, o_illegal, o_ex_valid}, 76'd2);
                else
                    check($sformatf("slot_%0d", n_slots),
                          {o_illegal, o_alu_op, o_operand_a, o_operand_b, o_rd, o_rd_wen, o_is_load}, e);
            end
        end
    end

    // Driver: present an instruction until accepted, queue its expected slot.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [75:0] exp, output int stalls);
        bit ok;
        ok         = 1'b0;
        stalls     = 0;
        i_id_valid = 1'b1;
        i_id_instr = instr;
        i_id_pc    = pc;
        for (int k = 0; k < 50; k++) begin
            @(negedge i_clk);
            if (o_id_ready) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        if (ok) begin
            exp_q.push_back(exp);
        end else begin
            check("issue_timeout", {75'b0, o_id_ready}, 76'd1);
        end
        @(posedge i_clk);
        #1;
        i_id_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        i_id_valid = 1'b0;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        logic [75:0] dropped;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[0] = 32'hDEAD;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        i_rst_n = 1'b0;
        i_id_valid = 1'b1;
        i_id_instr = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        i_id_pc = 32'h0;
        i_exm_wen = 1'b0; i_exm_rd = 5'd0; i_exm_data = 32'h0;
        i_mwb_wen = 1'b0; i_mwb_rd = 5'd0; i_mwb_data = 32'h0;
        i_flush = 1'b0;
        i_ex_ready = 1'b1;

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_slot", {o_illegal, o_alu_op, o_operand_a, o_operand_b, o_rd, o_rd_wen, o_is_load}, 76'd0);
        check("reset_ready_valid", {74'b0, o_id_ready, o_ex_valid}, 76'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        i_id_valid = 1'b0;

        // Basic ALU ops and shift-immediate.
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'h0, pk(4'b0000, 32'd5, 32'd7, 5'd3, 1, 0), s);
        rf[1] = 32'h8000_0010;
        issue(enc_i(12'h403, 5'd1, 3'b101, 5'd4, OP_IMM), 32'h0,
              pk(4'b1001, 32'h8000_0010, 32'h0000_0003, 5'd4, 1, 0), s);
        issue(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd5), 32'h0, pk(4'b0001, 32'h8000_0010, 32'd7, 5'd5, 1, 0), s);
        issue(enc_i(12'hFFF, 5'd1, 3'b000, 5'd10, OP_IMM), 32'h0,
              pk(4'b0000, 32'h8000_0010, 32'hFFFF_FFFF, 5'd10, 1, 0), s);
        rf[12] = 32'h25;
        issue(enc_r(7'h00, 5'd12, 5'd1, 3'b001, 5'd11), 32'h0, pk(4'b0111, 32'h8000_0010, 32'd5, 5'd11, 1, 0), s);
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd0), 32'h0, pk(4'b0110, 32'h8000_0010, 32'd7, 5'd0, 0, 0), s);

        // Forwarding priority.
        rf[1] = 32'd1;
        i_exm_wen = 1'b1; i_exm_rd = 5'd1; i_exm_data = 32'hAA;
        i_mwb_wen = 1'b1; i_mwb_rd = 5'd1; i_mwb_data = 32'hBB;
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'h0, pk(4'b0000, 32'hAA, 32'd7, 5'd3, 1, 0), s);
        i_exm_wen = 1'b0;
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'h0, pk(4'b0000, 32'hBB, 32'd7, 5'd3, 1, 0), s);
        i_exm_wen = 1'b1; i_exm_rd = 5'd0; i_mwb_wen = 1'b0;
        issue(enc_r(7'h00, 5'd2, 5'd0, 3'b000, 5'd3), 32'h0, pk(4'b0000, 32'h0, 32'd7, 5'd3, 1, 0), s);
        i_exm_wen = 1'b0;

        // Load-use hazard and its exemptions.
        rf[1] = 32'h100;
        rf[6] = 32'd3;
        issue(enc_i(12'd8, 5'd1, 3'b010, 5'd6, LOAD), 32'h0, pk(4'b0000, 32'h100, 32'd8, 5'd6, 1, 1), s);
        issue(enc_r(7'h00, 5'd2, 5'd6, 3'b000, 5'd7), 32'h0, pk(4'b0000, 32'd3, 32'd7, 5'd7, 1, 0), s);
        check("loaduse_stall", {44'b0, 32'(s)}, 76'd1);
        issue(enc_i(12'd4, 5'd1, 3'b010, 5'd0, LOAD), 32'h0, pk(4'b0000, 32'h100, 32'd4, 5'd0, 0, 1), s);
        issue(enc_r(7'h00, 5'd2, 5'd0, 3'b000, 5'd7), 32'h0, pk(4'b0000, 32'd0, 32'd7, 5'd7, 1, 0), s);
        check("load_x0_no_stall", {44'b0, 32'(s)}, 76'd0);
        issue(enc_i(12'd8, 5'd1, 3'b010, 5'd6, LOAD), 32'h0, pk(4'b0000, 32'h100, 32'd8, 5'd6, 1, 1), s);
        issue(enc_i(12'd6, 5'd2, 3'b000, 5'd8, OP_IMM), 32'h0, pk(4'b0000, 32'd7, 32'd6, 5'd8, 1, 0), s);
        check("imm_rs2_field_no_stall", {44'b0, 32'(s)}, 76'd0);

        // Backpressure: slot held, operands frozen even as rf changes.
        idle(2);
        rf[1] = 32'd5;
        i_ex_ready = 1'b0;
        issue(enc_i(12'd1, 5'd1, 3'b000, 5'd9, OP_IMM), 32'h0, pk(4'b0000, 32'd5, 32'd1, 5'd9, 1, 0), s);
        i_id_valid = 1'b1;
        i_id_instr = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        rf[1] = 32'd99;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check($sformatf("bp_hold_%0d", k),
                  {o_illegal, o_alu_op, o_operand_a, o_operand_b, o_rd, o_rd_wen, o_is_load},
                  pk(4'b0000, 32'd5, 32'd1, 5'd9, 1, 0));
            check($sformatf("bp_ready_%0d", k), {74'b0, o_id_ready, o_ex_valid}, 76'd1);
        end
        @(posedge i_clk);
        #1;
        i_id_valid = 1'b0;
        i_ex_ready = 1'b1;
        idle(1);

        // Flush a pending slot.
        i_ex_ready = 1'b0;
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd3), 32'h0, pk(4'b0100, 32'd99, 32'd7, 5'd3, 1, 0), s);
        i_flush = 1'b1;
        i_id_valid = 1'b1;
        dropped = exp_q.pop_back();
        @(negedge i_clk);
        check("flush_ready_low", {74'b0, o_id_ready, o_ex_valid}, 76'd1);
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        i_id_valid = 1'b0;
        i_ex_ready = 1'b1;
        check("flush_kills_slot", {75'b0, o_ex_valid}, 76'd0);

        // LUI, AUIPC and an unsupported opcode.
        issue({20'h12345, 5'd8, LUI}, 32'h0, pk(4'b1111, 32'h0, 32'h1234_5000, 5'd8, 1, 0), s);
        issue({20'h00001, 5'd9, AUIPC}, 32'h1000, pk(4'b1110, 32'h1000, 32'h1000, 5'd9, 1, 0), s);
        idle(1);
        issue(32'h0000_007F, 32'h0, ILLEGAL_ENTRY, s);
        @(negedge i_clk);
        @(negedge i_clk);
        check("illegal_one_cycle", {74'b0, o_illegal, o_ex_valid}, 76'd0);

        repeat (4) @(negedge i_clk);
        check("queue_drained", {44'b0, 32'(exp_q.size())}, 76'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
